// File: rtl/pipe_skid_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg_pkg
// Description : Shared pipeline definitions. Holds the handshake-stage state
//               encoding so hazard and stall logic can decode the same values.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_skid_reg_pkg;

  // Stage occupancy state; the numeric value equals the number of held entries
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int OCC_W = 2;

  // Number of entries held in a given state
  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
    logic [OCC_W-1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage : pipe_skid_reg_pkg
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Valid/ready pipeline stage. SKID=1 gives a two-entry skid
//               buffer with a registered in_ready (breaks the out_ready ->
//               in_ready timing path); SKID=0 gives a single pipe register with
//               combinational in_ready. out_data is always the main register.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                 WIDTH   = 32,
  parameter int                 SKID    = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Next-state and data-register update; flush wins over every transfer and
  // deliberately leaves the data registers untouched
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            // Only reachable with SKID=1: in pipe mode in_ready is low here
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and data registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      // in_ready is a pure flop: ready whenever the stage will not be full
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          in_ready_q <= 1'b0;
        end else begin
          in_ready_q <= (state_d != FULL);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_pipe
      logic ready_en_q;

      // Holds in_ready low during reset and until the first edge after release
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ready_en_q <= 1'b0;
        end else begin
          ready_en_q <= 1'b1;
        end
      end

      assign in_ready = ready_en_q & (~out_valid | out_ready);
    end
  endgenerate

endmodule : pipe_skid_reg
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Self-checking bench for pipe_skid_reg. One skid-mode and one
//               pipe-mode instance share stimulus; each is compared every
//               cycle against a queue-based model of the stage contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

  localparam int         WIDTH = 8;
  localparam logic [7:0] RSTV  = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic out_ready = 1'b0;

  logic       rdy_sk, vld_sk, rdy_pp, vld_pp;
  logic [7:0] dat_sk, dat_pp;
  logic [1:0] occ_sk, occ_pp;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the ordered list of held entries per instance
  logic [7:0] q_sk[$];
  logic [7:0] q_pp[$];
  bit started = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(WIDTH), .SKID(1), .RST_VAL(RSTV)) u_dut_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy_sk), .in_data(in_data),
    .out_valid(vld_sk), .out_ready(out_ready), .out_data(dat_sk),
    .occupancy(occ_sk)
  );

  pipe_skid_reg #(.WIDTH(WIDTH), .SKID(0), .RST_VAL(RSTV)) u_dut_pipe (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy_pp), .in_data(in_data),
    .out_valid(vld_pp), .out_ready(out_ready), .out_data(dat_pp),
    .occupancy(occ_pp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_rdy_sk();
    return started && (q_sk.size() < 2);
  endfunction

  function automatic bit exp_rdy_pp();
    return started && ((q_pp.size() == 0) || out_ready);
  endfunction

  // Apply one clock edge to the model using the inputs present at that edge
  task automatic model_edge();
    bit r_sk, r_pp;
    r_sk = exp_rdy_sk();
    r_pp = exp_rdy_pp();
    if (!rst) begin
      q_sk.delete();
      q_pp.delete();
      started = 1'b0;
    end else begin
      if (flush) begin
        q_sk.delete();
        q_pp.delete();
      end else begin
        if (q_sk.size() > 0 && out_ready) void'(q_sk.pop_front());
        if (in_valid && r_sk) q_sk.push_back(in_data);
        if (q_pp.size() > 0 && out_ready) void'(q_pp.pop_front());
        if (in_valid && r_pp) q_pp.push_back(in_data);
      end
      started = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("sk_ready", rdy_sk, exp_rdy_sk());
    check("sk_valid", vld_sk, q_sk.size() != 0);
    check("sk_occ",   occ_sk, q_sk.size());
    if (q_sk.size() != 0) check("sk_data", dat_sk, q_sk[0]);
    check("pp_ready", rdy_pp, exp_rdy_pp());
    check("pp_valid", vld_pp, q_pp.size() != 0);
    check("pp_occ",   occ_pp, q_pp.size());
    check("pp_occ_le1", occ_pp <= 2'd1, 1);
    if (q_pp.size() != 0) check("pp_data", dat_pp, q_pp[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Assert reset between edges and check the asynchronous effect at once
  task automatic async_reset();
    rst = 1'b0;
    #1;
    q_sk.delete();
    q_pp.delete();
    started = 1'b0;
    compare_all();
    check("rst_sk_data", dat_sk, RSTV);
    check("rst_pp_data", dat_pp, RSTV);
  endtask

  initial begin
    // Reset with a live input offered
    in_valid = 1'b1;
    in_data  = 8'hAA;
    #1;
    async_reset();
    tick();
    tick();
    check("rst_hold_sk_data", dat_sk, RSTV);
    rst = 1'b1;
    tick();
    check("rel_sk_ready", rdy_sk, 1);
    check("rel_pp_ready", rdy_pp, 1);
    in_valid = 1'b0;
    tick();

    // Streaming with continuous out_ready: one-cycle latency, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      tick();
      check("stream_data", dat_sk, i + 1);
      check("stream_ready", rdy_sk, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", vld_sk, 0);

    // Backpressure: A1, A2 fill the skid stage, A3 waits at the input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA1;
    tick();
    in_data   = 8'hA2;
    tick();
    check("bp_occ2", occ_sk, 2);
    check("bp_notready", rdy_sk, 0);
    in_data   = 8'hA3;
    tick();
    check("bp_hold_A1", dat_sk, 8'hA1);
    out_ready = 1'b1;
    tick();
    check("bp_out_A2", dat_sk, 8'hA2);
    tick();
    check("bp_out_A3", dat_sk, 8'hA3);
    in_valid = 1'b0;
    tick();
    tick();

    // Flush while full, with a same-cycle input that must be discarded
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    in_data   = 8'h22;
    tick();
    check("fl_occ2", occ_sk, 2);
    in_data = 8'hFF;
    flush   = 1'b1;
    tick();
    check("fl_occ0", occ_sk, 0);
    check("fl_valid0", vld_sk, 0);
    check("fl_ready", rdy_sk, 1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Mid-operation reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h33;
    tick();
    in_data   = 8'h44;
    tick();
    check("mr_occ2", occ_sk, 2);
    #2;
    async_reset();
    in_valid = 1'b0;
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_old", vld_sk, 0);
    end

    // Randomized traffic with occasional flush
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipe_skid_reg
`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, legal range 1..128.
REQ-002 Parameter SKID, default 1: 1 selects the two-entry skid buffer with registered in_ready; 0 selects a single-entry pipe register with combinational in_ready.
REQ-003 Parameter RST_VAL, default 0: the value loaded into all data registers on reset.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  producer offers in_data.
REQ-008 in_ready  output  1  block accepts in_data.
REQ-009 in_data  input  WIDTH  producer payload.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 out_data  output  WIDTH  consumer payload.
REQ-013 occupancy  output  2  number of held entries, 0..2.

Function
REQ-014 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-015 SKID=1 states SHALL be EMPTY (0 entries), BUSY (main entry held) and FULL (main and skid entries held).
REQ-016 In EMPTY, an input transfer SHALL load main and move to BUSY.
REQ-017 In BUSY: input and output transfer together -> main<=in_data, stay BUSY; input only -> skid<=in_data, go FULL; output only -> go EMPTY; neither -> hold.
REQ-018 In FULL, an output transfer SHALL set main<=skid and move to BUSY; in_ready=0, so no input transfer is possible.
REQ-019 For SKID=1, in_ready SHALL be a flop output equal to (next state != FULL), with no combinational path from out_ready.
REQ-020 For SKID=0, in_ready SHALL be (!out_valid | out_ready), combinational; the FULL state SHALL be unreachable.
REQ-021 out_valid SHALL be (state != EMPTY); out_data SHALL always be main; occupancy SHALL equal 0, 1 or 2 for EMPTY, BUSY or FULL.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-023 Data SHALL leave in arrival order; no entry SHALL be duplicated or lost except by flush.
REQ-024 Latency SHALL be 1 cycle, in_data to out_data, from EMPTY.
REQ-025 Throughput SHALL be one transfer per cycle in both modes when out_ready=1 continuously.
REQ-026 flush=1 SHALL force the state to EMPTY at the next edge, overriding all transfers; an input transfer in the same cycle SHALL be discarded.
REQ-027 flush SHALL leave data registers unchanged and raise in_ready at the next edge.
REQ-028 When in_valid=0, register contents SHALL not change except by a FULL->BUSY move or by reset.

Reset
REQ-029 rst=0 SHALL asynchronously set: state EMPTY, out_valid=0, occupancy=0, main=skid=RST_VAL, in_ready=0.
REQ-030 At the first rising edge after rst returns to 1, in_ready SHALL become 1; a mid-operation reset SHALL drop all held entries.

Structure
REQ-031 State encodings (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) SHALL live in the shared pipeline package or include, for reuse by the hazard and stall logic.
REQ-032 The block SHALL be one module with no sub-modules; the SKID mode SHALL be selected by a generate branch.

Verification
REQ-033 Reset: hold rst=0 with in_valid=1 and in_data=8'hAA (WIDTH=8) -> out_valid=0, in_ready=0, out_data=RST_VAL; in_ready=1 one edge after release.
REQ-034 Streaming: SKID=1, out_ready=1, feed 8'h01..8'h10 on consecutive cycles -> out_data 8'h01..8'h10 on consecutive cycles, each 1 cycle later, with no bubbles.
REQ-035 Backpressure: feed 8'hA1, 8'hA2, 8'hA3 with out_ready=0 -> occupancy reaches 2 and in_ready=0; out_data holds A1 and A3 stays at the input; after out_ready=1 the output is A1, A2, A3 in order.
REQ-036 Flush: occupancy=2 plus a same-cycle input of 8'hFF with flush=1 -> next cycle occupancy=0, out_valid=0, and FF never appears at the output.
REQ-037 Mid-operation reset: pulse rst=0 while occupancy=2 -> immediately occupancy=0 and out_valid=0; no old data appears at the output afterwards.
REQ-038 Mode check: SKID=0, toggle out_ready randomly for 1000 cycles -> in_ready equals (!out_valid | out_ready) every cycle, occupancy stays at most 1, and a scoreboard shows order preserved.
